// File: rtl/row_swap_scheduler.sv
// Per-line sequencer for the row drawer: ping-pong row bank select, background clear, swap pulse, RAM write mux.
// Optional macro ROW_SWAP_OVERRUN_COUNT_EN adds a saturating overrun_count output.
module row_swap_scheduler #(
  parameter int ROW_WIDTH = 480,
  parameter int ADDR_W    = 9,
  parameter int PIX_W     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_start,
  input  logic              frame_start,
  input  logic [7:0]        ent_count_in,
  output logic [7:0]        entities_number,
  input  logic [PIX_W-1:0]  bg_color,
  output logic              swap,
  input  logic [ADDR_W-1:0] drw_addr,
  input  logic [PIX_W-1:0]  drw_data,
  input  logic              drw_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_data,
  output logic              ram_wren,
  output logic              ram_bank,
  output logic              clearing,
  output logic              overrun
`ifdef ROW_SWAP_OVERRUN_COUNT_EN
  ,
  output logic [15:0]       overrun_count
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP, DRAW} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  data_q, data_d;
  logic              wren_q, wren_d;
  logic              bank_q, bank_d;
  logic              swap_q, swap_d;
  logic              clr_q, clr_d;
  logic              ovr_q, ovr_d;
  logic [7:0]        ent_q, ent_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      bank_q  <= 1'b0;
      swap_q  <= 1'b0;
      clr_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ent_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      bank_q  <= bank_d;
      swap_q  <= swap_d;
      clr_q   <= clr_d;
      ovr_q   <= ovr_d;
      ent_q   <= ent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    bank_d  = bank_q;
    swap_d  = 1'b0;
    clr_d   = 1'b0;
    ovr_d   = 1'b0;
    ent_d   = frame_start ? ent_count_in : ent_q;

    if (line_start) begin
      // A restart mid-clear keeps the bank so a half-cleared row is never shown.
      state_d = CLEAR;
      cnt_d   = '0;
      addr_d  = '0;
      data_d  = bg_color;
      wren_d  = 1'b1;
      clr_d   = 1'b1;
      if (state_q == CLEAR) ovr_d = 1'b1;
      else                  bank_d = ~bank_q;
    end else begin
      case (state_q)
        CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_d = SWAP;
            swap_d  = 1'b1;
          end else begin
            cnt_d  = cnt_q + ADDR_W'(1);
            addr_d = cnt_q + ADDR_W'(1);
            data_d = bg_color;
            wren_d = 1'b1;
            clr_d  = 1'b1;
          end
        end
        SWAP: state_d = DRAW;
        DRAW: begin
          addr_d = drw_addr;
          data_d = drw_data;
          wren_d = drw_wren;
        end
        default: ;
      endcase
    end
  end

`ifdef ROW_SWAP_OVERRUN_COUNT_EN
  logic [15:0] ovc_q, ovc_d;

  always_comb begin
    ovc_d = ovc_q;
    if (frame_start)                      ovc_d = {15'd0, ovr_d};
    else if (ovr_d && ovc_q != 16'hFFFF)  ovc_d = ovc_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovc_q <= '0;
    else        ovc_q <= ovc_d;
  end

  assign overrun_count = ovc_q;
`endif

  assign entities_number = ent_q;
  assign swap            = swap_q;
  assign ram_addr        = addr_q;
  assign ram_data        = data_q;
  assign ram_wren        = wren_q;
  assign ram_bank        = bank_q;
  assign clearing        = clr_q;
  assign overrun         = ovr_q;

endmodule
